// File: rtl/regfile_write_arbiter.sv
// Register-file write arbiter.
// After reset, the block clears every register by writing zero to each
// address in turn. It then arbitrates writes from two requesters, A and B,
// and alternates between them when both request in the same cycle. The
// outputs to the register file are registered. Ready is combinational.
module regfile_write_arbiter #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              a_valid,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              init_done,
   output logic              last_grant
);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1'b1);
   localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
   localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

   state_t            state_r, state_s;
   logic [ADDR_W-1:0] init_cnt_r, init_cnt_s;
   logic              wr_en_r, wr_en_s;
   logic [ADDR_W-1:0] wr_addr_r, wr_addr_s;
   logic [DATA_W-1:0] wr_data_r, wr_data_s;
   logic              init_done_r, init_done_s;
   logic              last_grant_r, last_grant_s;
   logic              a_ready_s, b_ready_s;

   // Arbitration: during the clear sweep nobody is ready. When both requesters
   // are valid, the grant goes to the requester that was not served last.
   always_comb begin
      a_ready_s = 1'b0;
      b_ready_s = 1'b0;
      case (state_r)
         ST_RUN: begin
            if (a_valid && b_valid) begin
               a_ready_s = last_grant_r;
               b_ready_s = ~last_grant_r;
            end else begin
               a_ready_s = a_valid;
               b_ready_s = b_valid;
            end
         end
         ST_INIT: begin
            a_ready_s = 1'b0;
            b_ready_s = 1'b0;
         end
         default: begin
            a_ready_s = 1'b0;
            b_ready_s = 1'b0;
         end
      endcase
   end

   // Next-state and next-output logic: clear sweep in INIT, forward accepted writes in RUN
   always_comb begin
      state_s      = state_r;
      init_cnt_s   = init_cnt_r;
      wr_en_s      = 1'b0;
      wr_addr_s    = wr_addr_r;
      wr_data_s    = wr_data_r;
      init_done_s  = init_done_r;
      last_grant_s = last_grant_r;
      case (state_r)
         ST_INIT: begin
            wr_en_s    = 1'b1;
            wr_addr_s  = init_cnt_r;
            wr_data_s  = ZERO_DATA;
            init_cnt_s = init_cnt_r + ONE_ADDR;
            if (init_cnt_r == LAST_ADDR) begin
               state_s     = ST_RUN;
               init_done_s = 1'b1;
            end else begin
               state_s     = ST_INIT;
            end
         end
         ST_RUN: begin
            if (a_valid && a_ready_s) begin
               wr_en_s      = 1'b1;
               wr_addr_s    = a_addr;
               wr_data_s    = a_data;
               last_grant_s = 1'b0;
            end else if (b_valid && b_ready_s) begin
               wr_en_s      = 1'b1;
               wr_addr_s    = b_addr;
               wr_data_s    = b_data;
               last_grant_s = 1'b1;
            end else begin
               wr_en_s      = 1'b0;
            end
         end
         default: begin
            state_s     = ST_INIT;
            init_cnt_s  = ZERO_ADDR;
            init_done_s = 1'b0;
         end
      endcase
   end

   // State and output registers. Asserting reset aborts all activity and
   // restarts the sweep from address 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= ST_INIT;
         init_cnt_r   <= ZERO_ADDR;
         wr_en_r      <= 1'b0;
         wr_addr_r    <= ZERO_ADDR;
         wr_data_r    <= ZERO_DATA;
         init_done_r  <= 1'b0;
         last_grant_r <= 1'b1;
      end else begin
         state_r      <= state_s;
         init_cnt_r   <= init_cnt_s;
         wr_en_r      <= wr_en_s;
         wr_addr_r    <= wr_addr_s;
         wr_data_r    <= wr_data_s;
         init_done_r  <= init_done_s;
         last_grant_r <= last_grant_s;
      end
   end

   assign a_ready    = a_ready_s;
   assign b_ready    = b_ready_s;
   assign wr_en      = wr_en_r;
   assign wr_addr    = wr_addr_r;
   assign wr_data    = wr_data_r;
   assign init_done  = init_done_r;
   assign last_grant = last_grant_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter.
// It applies directed scenarios followed by random traffic in which each
// requester holds its request until accepted. A behavioural model built from
// the block's rules supplies every expected value.
module tb_regfile_write_arbiter;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       a_valid = 1'b0, b_valid = 1'b0;
   logic [1:0] a_addr = 2'd0, b_addr = 2'd0;
   logic [7:0] a_data = 8'd0, b_data = 8'd0;
   logic       a_ready, b_ready, wr_en, init_done, last_grant;
   logic [1:0] wr_addr;
   logic [7:0] wr_data;

   int n_vec = 0;
   int n_err = 0;

   // Model state: sweep progress, last grant and the expected write port
   bit         m_init;
   int         m_cnt;
   bit         m_done;
   bit         m_lg;
   bit         m_wen;
   logic [1:0] m_waddr;
   logic [7:0] m_wdata;
   logic [7:0] rf_exp [4];
   logic [7:0] rf_obs [4];

   regfile_write_arbiter #(.DATA_W(8), .ADDR_W(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .init_done(init_done), .last_grant(last_grant)
   );

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_init  = 1'b1;
      m_cnt   = 0;
      m_done  = 1'b0;
      m_lg    = 1'b1;
      m_wen   = 1'b0;
      m_waddr = 2'd0;
      m_wdata = 8'd0;
   endtask

   // Assert reset between clock edges and check that the outputs clear at once.
   // Release reset just after a rising edge.
   task automatic do_reset();
      #2 reset_n = 1'b0;
      #1;
      check_eq("rst_wr_en",      {31'd0, wr_en},      32'd0);
      check_eq("rst_wr_addr",    {30'd0, wr_addr},    32'd0);
      check_eq("rst_wr_data",    {24'd0, wr_data},    32'd0);
      check_eq("rst_init_done",  {31'd0, init_done},  32'd0);
      check_eq("rst_last_grant", {31'd0, last_grant}, 32'd1);
      check_eq("rst_a_ready",    {31'd0, a_ready},    32'd0);
      check_eq("rst_b_ready",    {31'd0, b_ready},    32'd0);
      model_reset();
      @(posedge clk);
      #2 reset_n = 1'b1;
   endtask

   // One clock cycle: drive the inputs, check ready, then check the registered outputs after the edge
   task automatic cycle(input bit av, input logic [1:0] aa, input logic [7:0] ad,
                        input bit bv, input logic [1:0] ba, input logic [7:0] bd,
                        output bit a_acc, output bit b_acc);
      bit exp_a, exp_b;
      @(negedge clk);
      a_valid = av; a_addr = aa; a_data = ad;
      b_valid = bv; b_addr = ba; b_data = bd;
      #1;
      exp_a = 1'b0;
      exp_b = 1'b0;
      if (!m_init) begin
         if (av && bv) begin
            exp_a = m_lg;
            exp_b = !m_lg;
         end else begin
            exp_a = av;
            exp_b = bv;
         end
      end
      check_eq("a_ready", {31'd0, a_ready}, {31'd0, exp_a});
      check_eq("b_ready", {31'd0, b_ready}, {31'd0, exp_b});
      a_acc = av && exp_a;
      b_acc = bv && exp_b;
      @(posedge clk);
      #1;
      if (m_init) begin
         m_wen   = 1'b1;
         m_waddr = m_cnt[1:0];
         m_wdata = 8'd0;
         rf_exp[m_cnt] = 8'd0;
         m_cnt++;
         if (m_cnt == 4) begin
            m_init = 1'b0;
            m_done = 1'b1;
         end
      end else if (a_acc) begin
         m_wen = 1'b1; m_waddr = aa; m_wdata = ad; m_lg = 1'b0; rf_exp[aa] = ad;
      end else if (b_acc) begin
         m_wen = 1'b1; m_waddr = ba; m_wdata = bd; m_lg = 1'b1; rf_exp[ba] = bd;
      end else begin
         m_wen = 1'b0;
      end
      if (wr_en === 1'b1) rf_obs[wr_addr] = wr_data;
      check_eq("wr_en",      {31'd0, wr_en},      {31'd0, m_wen});
      check_eq("wr_addr",    {30'd0, wr_addr},    {30'd0, m_waddr});
      check_eq("wr_data",    {24'd0, wr_data},    {24'd0, m_wdata});
      check_eq("init_done",  {31'd0, init_done},  {31'd0, m_done});
      check_eq("last_grant", {31'd0, last_grant}, {31'd0, m_lg});
   endtask

   initial begin
      bit         aa_, ba_;
      bit         a_pend, b_pend;
      logic [1:0] pa_addr, pb_addr;
      logic [7:0] pa_data, pb_data;

      for (int i = 0; i < 4; i++) begin
         rf_exp[i] = 8'hxx;
         rf_obs[i] = 8'hxx;
      end
      model_reset();
      do_reset();

      // Clear sweep with no requests, followed by idle cycles
      repeat (6) cycle(1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 8'd0, aa_, ba_);

      // First contention after reset: the grants alternate A, B, A, B
      repeat (4) cycle(1'b1, 2'd1, 8'h11, 1'b1, 2'd3, 8'h33, aa_, ba_);
      cycle(1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 8'd0, aa_, ba_);

      // A alone: accepted in the same cycle, then written with last_grant = 0
      cycle(1'b1, 2'd2, 8'hA5, 1'b0, 2'd0, 8'd0, aa_, ba_);
      check_eq("req_a_accept", {31'd0, aa_}, 32'd1);

      // Both requesters target address 0 with last_grant = 0: B is written first, then A
      cycle(1'b1, 2'd0, 8'h01, 1'b1, 2'd0, 8'h02, aa_, ba_);
      check_eq("same_addr_b_first", {31'd0, ba_}, 32'd1);
      cycle(1'b1, 2'd0, 8'h01, 1'b0, 2'd0, 8'd0, aa_, ba_);
      check_eq("same_addr_a_next", {31'd0, aa_}, 32'd1);
      cycle(1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 8'd0, aa_, ba_);
      check_eq("same_addr_final", {24'd0, rf_obs[0]}, 32'h01);

      // Reset after two INIT writes: the sweep restarts at address 0
      do_reset();
      repeat (2) cycle(1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 8'd0, aa_, ba_);
      do_reset();
      repeat (5) cycle(1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 8'd0, aa_, ba_);

      // A valid throughout INIT: held off, then accepted in the first RUN cycle
      do_reset();
      repeat (4) cycle(1'b1, 2'd1, 8'h3C, 1'b0, 2'd0, 8'd0, aa_, ba_);
      cycle(1'b1, 2'd1, 8'h3C, 1'b0, 2'd0, 8'd0, aa_, ba_);
      check_eq("held_a_first_run", {31'd0, aa_}, 32'd1);
      cycle(1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 8'd0, aa_, ba_);

      // Random traffic: each request is held until accepted, with occasional resets
      a_pend = 1'b0;
      b_pend = 1'b0;
      pa_addr = 2'd0; pb_addr = 2'd0; pa_data = 8'd0; pb_data = 8'd0;
      for (int n = 0; n < 500; n++) begin
         if (!a_pend && ($urandom % 3 != 0)) begin
            a_pend = 1'b1; pa_addr = 2'($urandom); pa_data = 8'($urandom);
         end
         if (!b_pend && ($urandom % 3 != 0)) begin
            b_pend = 1'b1; pb_addr = 2'($urandom); pb_data = 8'($urandom);
         end
         cycle(a_pend, pa_addr, pa_data, b_pend, pb_addr, pb_data, aa_, ba_);
         if (aa_) a_pend = 1'b0;
         if (ba_) b_pend = 1'b0;
         if ($urandom % 120 == 0) do_reset();
      end
      repeat (2) cycle(1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 8'd0, aa_, ba_);

      // Register-file contents seen on the write port must match the model
      for (int i = 0; i < 4; i++) begin
         check_eq("rf_contents", {24'd0, rf_obs[i]}, {24'd0, rf_exp[i]});
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, register data width.
REQ-002 Parameter ADDR_W, default 2, register address width; register count is 2**ADDR_W.
REQ-003 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 Port reset_n, input, 1, asynchronous active-low reset.
REQ-006 Port a_valid, input, 1, requester A has a write pending.
REQ-007 Port a_addr, input, ADDR_W, requester A target register.
REQ-008 Port a_data, input, DATA_W, requester A write data.
REQ-009 Port a_ready, output, 1, requester A write accepted this cycle.
REQ-010 Port b_valid, input, 1, requester B has a write pending.
REQ-011 Port b_addr, input, ADDR_W, requester B target register.
REQ-012 Port b_data, input, DATA_W, requester B write data.
REQ-013 Port b_ready, output, 1, requester B write accepted this cycle.
REQ-014 Port wr_en, output, 1, register-file write enable (registered).
REQ-015 Port wr_addr, output, ADDR_W, register-file write address (registered).
REQ-016 Port wr_data, output, DATA_W, register-file write data (registered).
REQ-017 Port init_done, output, 1, high once the clear sweep has completed.
REQ-018 Port last_grant, output, 1, requester of the most recent accept (0=A, 1=B).

Function
REQ-019 The block SHALL implement a two-state FSM: INIT and RUN.
REQ-020 In INIT, each rising edge SHALL load wr_en=1, wr_addr=init_cnt, wr_data=0, then increment init_cnt.
REQ-021 When INIT issues address 2**ADDR_W-1, the FSM SHALL move to RUN on that edge; init_done SHALL go high on that same edge.
REQ-022 In INIT, a_ready and b_ready SHALL be 0 regardless of valids.
REQ-023 In RUN, ready SHALL be combinational from the valids: single valid -> that requester ready; both valid -> the requester not equal to last_grant ready; neither -> both 0.
REQ-024 At most one of a_ready/b_ready SHALL be high in any cycle.
REQ-025 An accept (valid & ready) SHALL cause the next edge to load wr_en=1, wr_addr/wr_data from the accepted requester; latency accept-to-wr_en is exactly 1 cycle.
REQ-026 With no accept in RUN, the next edge SHALL load wr_en=0; wr_addr/wr_data SHALL hold their previous values.
REQ-027 last_grant SHALL update on every accept to the accepted requester and hold otherwise.
REQ-028 Sustained throughput SHALL be one write per cycle; with both valid continuously, grants SHALL alternate A,B,A,B.
REQ-029 Both requesters targeting the same address SHALL be serialised in grant order; no merging or dropping.
REQ-030 Requesters SHALL hold valid, addr and data stable until accepted; the block does not buffer unaccepted requests.
REQ-031 No accept SHALL be lost: every accepted request produces exactly one wr_en pulse.

Reset
REQ-032 On reset_n low, asynchronously: wr_en=0, wr_addr=0, wr_data=0, init_done=0, last_grant=1, init_cnt=0, FSM=INIT.
REQ-033 With last_grant=1 after reset, the first contended grant in RUN SHALL go to A.
REQ-034 Reset asserted mid-INIT or mid-RUN SHALL abort all activity; the sweep restarts from address 0 after release.
REQ-035 The first INIT write SHALL occur on the first rising edge after reset_n deasserts.

Verification
REQ-036 Release reset, no valids -> wr_en high 4 cycles with wr_addr 0,1,2,3, wr_data 0; init_done high after 4th edge; then wr_en=0.
REQ-037 RUN, a_valid only, a_addr=2, a_data=8'hA5 -> a_ready=1 same cycle; next cycle wr_en=1, wr_addr=2, wr_data=8'hA5; last_grant=0.
REQ-038 RUN, both valid for 4 cycles (A: addr1 data 8'h11, B: addr3 data 8'h33, first contention after reset) -> grants A,B,A,B; wr_addr 1,3,1,3 one cycle later.
REQ-039 Both valid targeting addr 0 (A=8'h01, B=8'h02), last_grant=0 -> B written first, A next cycle; final wr_data 8'h01.
REQ-040 Assert reset_n low after 2 INIT writes -> outputs zero immediately; after release the sweep restarts at address 0 and runs 4 cycles.
REQ-041 a_valid high during INIT -> a_ready=0 throughout INIT; accepted on first RUN cycle, written the cycle after.
